// File: rtl/mam_mem_arbiter.sv
// Round-robin 2:1 arbiter sharing one memory port between two osd_mam-style masters.
// A grant is held until every beat of the granted transaction has completed.
module mam_mem_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    in_req_valid,
  output logic [1:0]                    in_req_ready,
  input  logic [1:0]                    in_req_rw,
  input  logic [1:0]                    in_req_burst,
  input  logic [2*ADDR_WIDTH-1:0]       in_req_addr,
  input  logic [2*14-1:0]               in_req_beats,
  input  logic [1:0]                    in_write_valid,
  output logic [1:0]                    in_write_ready,
  input  logic [2*DATA_WIDTH-1:0]       in_write_data,
  input  logic [2*(DATA_WIDTH/8)-1:0]   in_write_strb,
  output logic [1:0]                    in_read_valid,
  input  logic [1:0]                    in_read_ready,
  output logic [2*DATA_WIDTH-1:0]       in_read_data,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic                          mem_req_rw,
  output logic                          mem_req_burst,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr,
  output logic [13:0]                   mem_req_beats,
  output logic                          mem_write_valid,
  output logic [DATA_WIDTH-1:0]         mem_write_data,
  output logic [DATA_WIDTH/8-1:0]       mem_write_strb,
  input  logic                          mem_write_ready,
  input  logic                          mem_read_valid,
  input  logic [DATA_WIDTH-1:0]         mem_read_data,
  output logic                          mem_read_ready,
  output logic [1:0]                    grant
);
  localparam int SW = DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_READ  = 2'd3;

  logic [1:0]  state;
  logic        owner;
  logic        prio;
  logic [13:0] remain;

  logic                  own_req_valid;
  logic                  own_rw;
  logic                  own_burst;
  logic                  own_write_valid;
  logic                  own_read_ready;
  logic [ADDR_WIDTH-1:0] own_addr;
  logic [13:0]           own_beats;
  logic [DATA_WIDTH-1:0] own_wdata;
  logic [SW-1:0]         own_wstrb;
  logic [1:0]            sel;
  logic                  st_req;
  logic                  st_write;
  logic                  st_read;
  logic                  req_fire;
  logic                  write_fire;
  logic                  read_fire;
  logic                  beat_fire;

  assign own_req_valid   = in_req_valid[owner];
  assign own_rw          = in_req_rw[owner];
  assign own_burst       = in_req_burst[owner];
  assign own_write_valid = in_write_valid[owner];
  assign own_read_ready  = in_read_ready[owner];
  assign own_addr  = owner ? in_req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : in_req_addr[ADDR_WIDTH-1:0];
  assign own_beats = owner ? in_req_beats[27:14] : in_req_beats[13:0];
  assign own_wdata = owner ? in_write_data[2*DATA_WIDTH-1:DATA_WIDTH] : in_write_data[DATA_WIDTH-1:0];
  assign own_wstrb = owner ? in_write_strb[2*SW-1:SW] : in_write_strb[SW-1:0];

  assign st_req   = (state == ST_REQ);
  assign st_write = (state == ST_WRITE);
  assign st_read  = (state == ST_READ);
  assign sel      = owner ? 2'b10 : 2'b01;
  assign grant    = (state == ST_IDLE) ? 2'b00 : sel;

  // Forwarded fields are zeroed outside their phase so the memory never sees stale requests.
  assign mem_req_valid = st_req & own_req_valid;
  assign mem_req_rw    = st_req & own_rw;
  assign mem_req_burst = st_req & own_burst;
  assign mem_req_addr  = st_req ? own_addr : '0;
  assign mem_req_beats = st_req ? own_beats : '0;
  assign in_req_ready  = sel & {2{st_req & mem_req_ready}};

  assign mem_write_valid = st_write & own_write_valid;
  assign mem_write_data  = st_write ? own_wdata : '0;
  assign mem_write_strb  = st_write ? own_wstrb : '0;
  assign in_write_ready  = sel & {2{st_write & mem_write_ready}};

  assign mem_read_ready = st_read & own_read_ready;
  assign in_read_valid  = sel & {2{st_read & mem_read_valid}};
  assign in_read_data   = {2{mem_read_data}};

  assign req_fire   = mem_req_valid & mem_req_ready;
  assign write_fire = mem_write_valid & mem_write_ready;
  assign read_fire  = mem_read_valid & mem_read_ready;
  assign beat_fire  = write_fire | read_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      owner  <= 1'b0;
      prio   <= 1'b0;
      remain <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|in_req_valid) begin
            owner <= (&in_req_valid) ? prio : in_req_valid[1];
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (req_fire) begin
            // A zero-length burst still moves one word.
            remain <= (own_burst && (own_beats != 14'd0)) ? own_beats : 14'd1;
            state  <= own_rw ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE, ST_READ: begin
          if (beat_fire) begin
            remain <= remain - 14'd1;
            if (remain == 14'd1) begin
              prio  <= ~owner;
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mam_mem_arbiter.md
# mam_mem_arbiter

Two-to-one arbiter that shares one system-memory port between two `osd_mam`-style memory masters, e.g. two MAM instances or a MAM plus a DMA engine. It sits between the requesters' memory-side interfaces (req/write/read handshakes) and the single memory controller port. Arbitration is round-robin per transaction. A grant is held until every beat of the granted transaction has completed, so bursts are never interleaved.

## Interface
Parameters:
- `DATA_WIDTH`, 16, data bus width in bits; must be a multiple of 8
- `ADDR_WIDTH`, 32, address width

Ports (requester-side buses are packed; index i occupies slice [i*W +: W]):
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_req_valid`, `in_req_ready`  in/out  2  per-requester request handshake
- `in_req_rw`, `in_req_burst`  in  2  1=write / 1=burst, per requester
- `in_req_addr`  in  2*ADDR_WIDTH  request address
- `in_req_beats`  in  2*14  burst length in words
- `in_write_valid`, `in_write_ready`  in/out  2  write beat handshake
- `in_write_data`  in  2*DATA_WIDTH  write data
- `in_write_strb`  in  2*DATA_WIDTH/8  byte strobes
- `in_read_valid`, `in_read_ready`  out/in  2  read beat handshake
- `in_read_data`  out  2*DATA_WIDTH  read data
- `mem_req_valid`, `mem_req_ready`  out/in  1  memory request handshake
- `mem_req_rw`, `mem_req_burst`, `mem_req_addr`, `mem_req_beats`  out  1/1/ADDR_WIDTH/14  forwarded request
- `mem_write_valid`, `mem_write_data`, `mem_write_strb`, `mem_write_ready`  out/out/out/in  forwarded write beat
- `mem_read_valid`, `mem_read_data`, `mem_read_ready`  in/in/out  memory read beat
- `grant`  out  2  one-hot owner of memory port; 2'b00 when idle

## Operation
- States: IDLE, REQ, WRITE, READ. Registers: `state`, `owner` (1 bit), `prio` (1 bit, preferred requester), `remain` (14 bit).
- IDLE:
  - If exactly one `in_req_valid` is set, that requester is latched as owner.
  - If both are set, `prio` wins.
  - Go to REQ, `grant` = one-hot(owner).
  - No handshake completes in IDLE; all ready/valid outputs are 0.
- REQ:
  - `mem_req_*` = owner's `in_req_*`; owner's `in_req_ready` = `mem_req_ready`.
  - On `mem_req_valid & mem_req_ready`, `remain` is loaded with `in_req_beats` if burst, else 1.
  - Beats=0 with burst=1 is loaded as 1.
  - Then go to WRITE if rw=1, else READ.
- WRITE:
  - Owner's write bus is routed to `mem_write_*`; `in_write_ready[owner]` = `mem_write_ready`.
  - Each accepted beat decrements `remain`.
  - When the beat with `remain==1` is accepted: `prio` <= ~owner, go to IDLE.
- READ:
  - `mem_read_data` is broadcast to both `in_read_data` slices.
  - `in_read_valid[owner]` = `mem_read_valid`; `mem_read_ready` = `in_read_ready[owner]`.
  - Count and exit exactly as in WRITE.
- Non-owner: `in_req_ready`, `in_write_ready`, `in_read_valid` are held 0 at all times. A pending non-owner request stays pending with no loss.
- `mem_write_valid` is 0 outside WRITE; `mem_req_valid` is 0 outside REQ; `mem_read_ready` is 0 outside READ.
- Beats presented by the owner during REQ are not forwarded; only the WRITE state passes them.

## Timing
- Reset:
  - State IDLE, `prio`=0, `owner`=0, `remain`=0, `grant`=0.
  - All valid/ready outputs 0; `mem_req_*` data outputs 0.
- Reset mid-transaction: abandoned immediately; outputs return to reset values in the cycle following the reset edge. The memory controller shares `rst`.
- Arbitration latency: requester valid sampled in IDLE at cycle N. Owner registered at edge N+1. `mem_req_valid` is high during cycle N+1 (one bubble).
- Per-transaction overhead is one IDLE cycle. Back-to-back transactions from one requester are separated by exactly one cycle.
- Fairness: with both requesting continuously, grants alternate 0,1,0,1.
- Request, write and read paths in REQ/WRITE/READ are combinational pass-through; no extra latency per beat.
- Backpressure: `remain` holds while a handshake is not completed. Stalls of any length are legal in every state.
- Simultaneous events:
  - A requester deasserting `in_req_valid` in REQ before the handshake is a protocol violation and undefined.
  - A new request arriving on the last beat is seen in the following IDLE cycle.

## Test plan
- **Single burst write:** requester 0 writes burst, addr 0x100, beats=3, data 0x0001..0x0003, memory always ready. Expect one `mem_req` with addr 0x100 and beats 3, three write beats in order, `grant`=01 then 00, and `prio`=1 afterwards.
- **Simultaneous requests after reset:** requester 0 single write 0x000f; requester 1 burst read, beats=2, memory returns 0xAAAA, 0xBBBB. Expect requester 0 served first, then requester 1 `mem_req_valid` exactly one cycle after requester 0's last beat. `in_read_valid[1]` pulses twice; `in_read_valid[0]` stays 0.
- **Fairness:** both requesters issue four back-to-back single writes each. Expect the `grant` sequence 01,10,01,10,01,10,01,10.
- **Backpressure:** `mem_write_ready`=0 for 5 cycles in the middle of a 4-beat burst. Expect `in_write_ready[owner]`=0 during the stall, no beat duplicated or lost, and the memory receiving 4 beats total.
- **Degenerate burst and single:** burst with beats=0, then single write with beats=7 and burst=0. Expect each to complete after exactly one write beat and return to IDLE.
- **Reset mid-read:** assert `rst` during beat 2 of a 5-beat read. Expect all outputs at reset values the next cycle and `prio`=0. A fresh request from requester 1 is then granted normally.
